// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and types shared by the CPU datapath and the boot-time
// instruction memory loader.
//   ADDR_W          instruction memory address width (matches PC width)
//   DATA_W          instruction width
//   IMEM_MAX_WORDS  largest image the loader accepts, in words
//   loaderState_t   imem_loader FSM state encoding
package cpu_pkg;

   localparam int unsigned ADDR_W         = 12;
   localparam int unsigned DATA_W         = 16;
   localparam int unsigned IMEM_MAX_WORDS = 4096;

   typedef enum logic [2:0] {
      IDLE,
      LEN_HI,
      LEN_LO,
      DATA_HI,
      DATA_LO,
      CHECK,
      RUN,
      ERROR
   } loaderState_t;

endpackage

// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the instruction memory.
// Receives a framed byte stream (16-bit length, payload words high byte first,
// optional 8-bit checksum) and writes the words sequentially from address 0.
// The pipeline enable is held low until a complete image has been accepted.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-low reset
//   start       one-cycle load request (ignored while busy)
//   rx_valid    byte available on rx_data
//   rx_data     received byte
//   rx_ready    loader accepts a byte this cycle (decoded from state only)
//   imem_we     registered one-cycle write strobe
//   imem_addr   write address (holds when imem_we=0)
//   imem_wdata  write data (holds when imem_we=0)
//   cpu_enable  pipeline enable, high only in RUN
//   busy        load in progress (LEN_HI through CHECK)
//   done        image loaded and accepted
//   err         frame rejected
//
// Configuration macro:
//   IMEM_LOADER_CKSUM_EN  when defined, a trailing checksum byte (8-bit sum of
//                         the payload bytes) is required after the last word;
//                         when undefined the FSM enters RUN right after the
//                         final word and no checksum logic is built.
module imem_loader
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_W    = cpu_pkg::ADDR_W,
   parameter int unsigned DATA_W    = cpu_pkg::DATA_W,
   parameter int unsigned MAX_WORDS = cpu_pkg::IMEM_MAX_WORDS
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [DATA_W-1:0] imem_wdata,
   output logic              cpu_enable,
   output logic              busy,
   output logic              done,
   output logic              err
);

   loaderState_t state;
   loaderState_t stateNext;

   logic [7:0]  lenHi;
   logic [15:0] len;
   logic [15:0] lenIn;
   logic [15:0] wordIdx;
   logic [7:0]  hiReg;
   logic        byteTaken;
   logic        lastWord;
   logic        lenBad;
`ifdef IMEM_LOADER_CKSUM_EN
   logic [7:0]  cksum;
`endif

   assign byteTaken = rx_valid && rx_ready;
   assign lenIn     = {lenHi, rx_data};
   assign lenBad    = (lenIn == '0) || (lenIn > 16'(MAX_WORDS));
   assign lastWord  = (wordIdx == len - 16'd1);

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Next-state logic
   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (start) stateNext = LEN_HI;
         LEN_HI:  if (byteTaken) stateNext = LEN_LO;
         LEN_LO:  if (byteTaken) stateNext = lenBad ? ERROR : DATA_HI;
         DATA_HI: if (byteTaken) stateNext = DATA_LO;
         DATA_LO: begin
            if (byteTaken) begin
`ifdef IMEM_LOADER_CKSUM_EN
               stateNext = lastWord ? CHECK : DATA_HI;
`else
               stateNext = lastWord ? RUN : DATA_HI;
`endif
            end
         end
`ifdef IMEM_LOADER_CKSUM_EN
         CHECK:   if (byteTaken) stateNext = (rx_data == cksum) ? RUN : ERROR;
`endif
         RUN:     if (start) stateNext = LEN_HI;
         ERROR:   if (start) stateNext = LEN_HI;
         default: stateNext = IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      rx_ready   = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      err        = 1'b0;
      cpu_enable = 1'b0;
      case (state)
         LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK: begin
            rx_ready = 1'b1;
            busy     = 1'b1;
         end
         RUN: begin
            done       = 1'b1;
            cpu_enable = 1'b1;
         end
         ERROR:   err = 1'b1;
         default: ;
      endcase
   end

   // Datapath: length capture, word assembly and the registered write port.
   // The write is issued on the edge that accepts the low byte, so the strobe
   // appears in the following cycle while the next high byte can already be
   // accepted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lenHi      <= '0;
         len        <= '0;
         wordIdx    <= '0;
         hiReg      <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
         cksum      <= '0;
`endif
      end else begin
         imem_we <= 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
         if (stateNext == LEN_HI && state != LEN_HI) cksum <= '0;
`endif
         if (byteTaken) begin
            case (state)
               LEN_HI: lenHi <= rx_data;
               LEN_LO: begin
                  len     <= lenIn;
                  wordIdx <= '0;
               end
               DATA_HI: begin
                  hiReg <= rx_data;
`ifdef IMEM_LOADER_CKSUM_EN
                  cksum <= cksum + rx_data;
`endif
               end
               DATA_LO: begin
                  imem_we    <= 1'b1;
                  imem_addr  <= wordIdx[ADDR_W-1:0];
                  imem_wdata <= DATA_W'({hiReg, rx_data});
                  wordIdx    <= wordIdx + 16'd1;
`ifdef IMEM_LOADER_CKSUM_EN
                  cksum      <= cksum + rx_data;
`endif
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: self-checking bench for imem_loader.
// Table of frames applied in a loop, plus hand sequences for reset behaviour.
// Expected memory writes are queued when a frame is driven and compared by a
// monitor whenever imem_we pulses.
module tb_imem_loader;

   logic        clk;
   logic        reset;
   logic        start;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        imem_we;
   logic [11:0] imem_addr;
   logic [15:0] imem_wdata;
   logic        cpu_enable;
   logic        busy;
   logic        done;
   logic        err;

   int unsigned checks   = 0;
   int unsigned failures = 0;
   int unsigned weCount  = 0;

   logic [27:0] expQ [$];

   typedef struct {
      logic [7:0]  b [12];
      int unsigned n;
      logic        hasCk;
      int unsigned gap;
      logic        expDoneCk;
      logic        expErrCk;
      logic        expDoneNoCk;
      logic        expErrNoCk;
   } vec_t;

   vec_t tbl [5];
   vec_t v;

   imem_loader #(
      .ADDR_W   (12),
      .DATA_W   (16),
      .MAX_WORDS(4096)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .rx_ready  (rx_ready),
      .imem_we   (imem_we),
      .imem_addr (imem_addr),
      .imem_wdata(imem_wdata),
      .cpu_enable(cpu_enable),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Write monitor / scoreboard
   always @(negedge clk) begin
      if (reset && imem_we) begin
         logic [27:0] e;
         weCount++;
         if (expQ.size() == 0) begin
            check("spuriousWrite", {4'h0, imem_addr, imem_wdata}, 32'hFFFF_FFFF);
         end else begin
            e = expQ.pop_front();
            check("writeAddr", 32'(imem_addr), 32'(e[27:16]));
            check("writeData", 32'(imem_wdata), 32'(e[15:0]));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sendByte(input logic [7:0] b, input int unsigned gap);
      int unsigned waitCnt;
      rx_valid = 1'b1;
      rx_data  = b;
      waitCnt  = 0;
      while (!rx_ready && waitCnt < 20) begin
         tick();
         waitCnt++;
      end
      if (!rx_ready) begin
         checks++;
         failures++;
         $display("FAIL byteTimeout: rx_ready stayed 0 for byte 0x%0h", b);
      end else begin
         tick();
      end
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      for (int unsigned i = 0; i < gap; i++) tick();
   endtask

   task automatic pulseStart();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Queue the writes a well-formed frame must produce
   task automatic modelFrame(input vec_t f);
      int unsigned len;
      len = {f.b[0], f.b[1]};
      if (len >= 1 && len <= 4096) begin
         for (int unsigned i = 0; i < len; i++) begin
            expQ.push_back({12'(i), f.b[2+2*i], f.b[3+2*i]});
         end
      end
   endtask

   task automatic runFrame(input vec_t f, input string tag);
      int unsigned n;
      logic expDone;
      logic expErr;
`ifdef IMEM_LOADER_CKSUM_EN
      n       = f.n;
      expDone = f.expDoneCk;
      expErr  = f.expErrCk;
`else
      n       = f.hasCk ? f.n - 1 : f.n;
      expDone = f.expDoneNoCk;
      expErr  = f.expErrNoCk;
`endif
      pulseStart();
      check({tag, ".busyAfterStart"}, 32'(busy), 32'd1);
      check({tag, ".readyAfterStart"}, 32'(rx_ready), 32'd1);
      check({tag, ".errClearedOnStart"}, 32'(err), 32'd0);
      check({tag, ".cpuEnDuringLoad"}, 32'(cpu_enable), 32'd0);
      modelFrame(f);
      for (int unsigned i = 0; i < n; i++) sendByte(f.b[i], f.gap);
      repeat (3) tick();
      check({tag, ".done"}, 32'(done), 32'(expDone));
      check({tag, ".err"}, 32'(err), 32'(expErr));
      check({tag, ".cpuEnable"}, 32'(cpu_enable), 32'(expDone));
      check({tag, ".busyEnd"}, 32'(busy), 32'd0);
      check({tag, ".readyEnd"}, 32'(rx_ready), 32'd0);
      check({tag, ".pendingWrites"}, 32'(expQ.size()), 32'd0);
      expQ.delete();
   endtask

   task automatic checkAllZero(input string tag);
      check({tag, ".rxReady"}, 32'(rx_ready), 32'd0);
      check({tag, ".we"}, 32'(imem_we), 32'd0);
      check({tag, ".addr"}, 32'(imem_addr), 32'd0);
      check({tag, ".wdata"}, 32'(imem_wdata), 32'd0);
      check({tag, ".cpuEnable"}, 32'(cpu_enable), 32'd0);
      check({tag, ".busy"}, 32'(busy), 32'd0);
      check({tag, ".done"}, 32'(done), 32'd0);
      check({tag, ".err"}, 32'(err), 32'd0);
   endtask

   initial begin
      // Stimulus table
      tbl[0].b = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hBF, 8'h00, 8'h00, 8'h00};
      tbl[0].n = 9; tbl[0].hasCk = 1'b1; tbl[0].gap = 0;
      tbl[0].expDoneCk = 1'b1; tbl[0].expErrCk = 1'b0; tbl[0].expDoneNoCk = 1'b1; tbl[0].expErrNoCk = 1'b0;

      tbl[1].b = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'h90, 8'h00, 8'h00, 8'h00};
      tbl[1].n = 9; tbl[1].hasCk = 1'b1; tbl[1].gap = 0;
      tbl[1].expDoneCk = 1'b0; tbl[1].expErrCk = 1'b1; tbl[1].expDoneNoCk = 1'b1; tbl[1].expErrNoCk = 1'b0;

      tbl[2].b = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      tbl[2].n = 2; tbl[2].hasCk = 1'b0; tbl[2].gap = 0;
      tbl[2].expDoneCk = 1'b0; tbl[2].expErrCk = 1'b1; tbl[2].expDoneNoCk = 1'b0; tbl[2].expErrNoCk = 1'b1;

      tbl[3].b = '{8'h10, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      tbl[3].n = 2; tbl[3].hasCk = 1'b0; tbl[3].gap = 0;
      tbl[3].expDoneCk = 1'b0; tbl[3].expErrCk = 1'b1; tbl[3].expDoneNoCk = 1'b0; tbl[3].expErrNoCk = 1'b1;

      tbl[4].b = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      tbl[4].n = 7; tbl[4].hasCk = 1'b1; tbl[4].gap = 2;
      tbl[4].expDoneCk = 1'b1; tbl[4].expErrCk = 1'b0; tbl[4].expDoneNoCk = 1'b1; tbl[4].expErrNoCk = 1'b0;

      // Reset then idle
      reset    = 1'b0;
      start    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (3) tick();
      checkAllZero("inReset");
      reset = 1'b1;
      repeat (4) tick();
      checkAllZero("idle");
      check("idle.writes", 32'(weCount), 32'd0);

      // Table-driven frames
      for (int unsigned i = 0; i < 5; i++) begin
         runFrame(tbl[i], $sformatf("vec%0d", i));
      end

      // Reset mid-load after 5 accepted bytes (one word already written)
      pulseStart();
      expQ.push_back({12'h000, 16'h1234});
      sendByte(8'h00, 0);
      sendByte(8'h03, 0);
      sendByte(8'h12, 0);
      sendByte(8'h34, 0);
      sendByte(8'hAB, 0);
      check("midLoad.busy", 32'(busy), 32'd1);
      #1;
      reset = 1'b0;
      #1;
      checkAllZero("asyncReset");
      check("asyncReset.pendingWrites", 32'(expQ.size()), 32'd0);
      repeat (2) tick();
      reset = 1'b1;
      tick();
      checkAllZero("afterReset");

      v.b = '{8'h00, 8'h01, 8'h5A, 8'hA5, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      v.n = 5; v.hasCk = 1'b1; v.gap = 0;
      v.expDoneCk = 1'b1; v.expErrCk = 1'b0; v.expDoneNoCk = 1'b1; v.expErrNoCk = 1'b0;
      runFrame(v, "reload");

      // start while busy must not restart the frame
      pulseStart();
      modelFrame(tbl[4]);
      sendByte(8'h00, 0);
      start = 1'b1;
      sendByte(8'h02, 0);
      start = 1'b0;
      for (int unsigned i = 2; i < 7; i++) begin
`ifndef IMEM_LOADER_CKSUM_EN
         if (i == 6) break;
`endif
         sendByte(tbl[4].b[i], 0);
      end
      repeat (3) tick();
      check("startWhileBusy.done", 32'(done), 32'd1);
      check("startWhileBusy.pendingWrites", 32'(expQ.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL globalTimeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
